// File: rtl/fpga_uram_arb_pkg.sv
// Shared types and defaults for the two-requester URAM port-A arbiter.
// State encodings match the CLEAR/RUN values used by the rest of the memory subsystem.
package fpga_uram_arb_pkg;

    localparam int DefDataWidth = 64;
    localparam int DefAddrWidth = 12;
    localparam int IdWidth      = 1;

    typedef enum logic {
        FPGA_URAM_ARB_CLEAR = 1'b0,
        FPGA_URAM_ARB_RUN   = 1'b1
    } arbState_e;

    typedef logic [IdWidth-1:0] reqId_t;

    // With two requesters, the "other" requester is simply the inverted ID.
    function automatic reqId_t otherId(input reqId_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/fpga_uram_arb_rr.sv
// Two-way round-robin grant: combinational grant from eligibility, 1-bit pointer that
// moves to the non-granted requester whenever a grant is taken.
module fpga_uram_arb_rr
    import fpga_uram_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Eligible,
    input  logic       Advance,
    output logic [1:0] Grant,
    output reqId_t     GrantId
);

    reqId_t pointer;

    always_comb begin
        Grant   = 2'b00;
        GrantId = '0;
        case (Eligible)
            2'b01: begin
                Grant   = 2'b01;
                GrantId = 1'b0;
            end
            2'b10: begin
                Grant   = 2'b10;
                GrantId = 1'b1;
            end
            2'b11: begin
                Grant   = (pointer == 1'b1) ? 2'b10 : 2'b01;
                GrantId = pointer;
            end
            default: begin
                Grant   = 2'b00;
                GrantId = '0;
            end
        endcase
    end

    // Advance is low while the block is not accepting, so a grant that is not taken
    // leaves the pointer alone.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pointer <= '0;
        end else if (Advance && (Eligible != 2'b00)) begin
            pointer <= otherId(GrantId);
        end
    end

endmodule

// File: rtl/fpga_uram_arb.sv
// Arbiter/sequencer for URAM port A: two valid/ready requesters, one response each,
// 2-cycle accept-to-response latency. FPGA_URAM_ARB_CLR_EN enables the post-reset zero-fill.
module fpga_uram_arb
    import fpga_uram_arb_pkg::*;
#(
    parameter int DATAWIDTH = DefDataWidth,
    parameter int ADDRWIDTH = DefAddrWidth,
    parameter int MEMDEPTH  = 2**ADDRWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Req0Valid,
    output logic                 Req0Ready,
    input  logic                 Req0Write,
    input  logic [ADDRWIDTH-1:0] Req0Addr,
    input  logic [DATAWIDTH-1:0] Req0Wdata,
    input  logic                 Req1Valid,
    output logic                 Req1Ready,
    input  logic                 Req1Write,
    input  logic [ADDRWIDTH-1:0] Req1Addr,
    input  logic [DATAWIDTH-1:0] Req1Wdata,
    output logic                 Rsp0Valid,
    input  logic                 Rsp0Ready,
    output logic [DATAWIDTH-1:0] Rsp0Rdata,
    output logic                 Rsp1Valid,
    input  logic                 Rsp1Ready,
    output logic [DATAWIDTH-1:0] Rsp1Rdata,
    output logic [ADDRWIDTH-1:0] MemAddr,
    output logic [DATAWIDTH-1:0] MemDataIn,
    output logic                 MemWriteEnable,
    input  logic [DATAWIDTH-1:0] MemDataOut,
    output logic                 InitDone,
    output arbState_e            DbgState
);

    // Handshakes on both channels: a transfer happens at a posedge where Valid and Ready
    // are both high; the sender keeps Valid and payload stable until then. Ready may
    // depend on Valid.

    if (MEMDEPTH < 1 || MEMDEPTH > 2**ADDRWIDTH) begin : gDepthCheck
        $error("fpga_uram_arb: MEMDEPTH must be in 1..2**ADDRWIDTH");
    end

    arbState_e state;
    logic      busy0;
    logic      busy1;
    logic      s1Valid;
    reqId_t    s1Id;
    logic      s2Valid;
    reqId_t    s2Id;

`ifdef FPGA_URAM_ARB_CLR_EN
    localparam logic [ADDRWIDTH-1:0] LastAddr = ADDRWIDTH'(MEMDEPTH - 1);
    logic [ADDRWIDTH-1:0] clrCnt;
`endif

    logic [1:0] eligible;
    logic [1:0] grant;
    reqId_t     grantId;
    logic       accept;
    logic       rsp0Done;
    logic       rsp1Done;

    logic                 selWrite;
    logic [ADDRWIDTH-1:0] selAddr;
    logic [DATAWIDTH-1:0] selWdata;

    assign eligible = {Req1Valid & ~busy1, Req0Valid & ~busy0};

    fpga_uram_arb_rr uRr (
        .Clk      (Clk),
        .Rst      (Rst),
        .Eligible (eligible),
        .Advance  (InitDone),
        .Grant    (grant),
        .GrantId  (grantId)
    );

    // Grant only ever names an eligible requester, so busy is already folded in.
    assign Req0Ready = InitDone & grant[0];
    assign Req1Ready = InitDone & grant[1];
    assign accept    = Req0Ready | Req1Ready;
    assign rsp0Done  = Rsp0Valid & Rsp0Ready;
    assign rsp1Done  = Rsp1Valid & Rsp1Ready;
    assign DbgState  = state;

    always_comb begin
        selWrite = Req0Write;
        selAddr  = Req0Addr;
        selWdata = Req0Wdata;
        if (grantId == 1'b1) begin
            selWrite = Req1Write;
            selAddr  = Req1Addr;
            selWdata = Req1Wdata;
        end
    end

    // FSM and S1 stage: the RAM port registers are the FSM's registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
`ifdef FPGA_URAM_ARB_CLR_EN
            state    <= FPGA_URAM_ARB_CLEAR;
            InitDone <= 1'b0;
            clrCnt   <= '0;
`else
            state    <= FPGA_URAM_ARB_RUN;
            InitDone <= 1'b1;
`endif
            MemAddr        <= '0;
            MemDataIn      <= '0;
            MemWriteEnable <= 1'b0;
            s1Valid        <= 1'b0;
            s1Id           <= '0;
        end else begin
            InitDone       <= (state == FPGA_URAM_ARB_RUN);
            MemWriteEnable <= 1'b0;
            s1Valid        <= 1'b0;
            case (state)
                FPGA_URAM_ARB_CLEAR: begin
`ifdef FPGA_URAM_ARB_CLR_EN
                    MemWriteEnable <= 1'b1;
                    MemAddr        <= clrCnt;
                    MemDataIn      <= '0;
                    clrCnt         <= clrCnt + 1'b1;
                    if (clrCnt == LastAddr) begin
                        state <= FPGA_URAM_ARB_RUN;
                    end
`else
                    state <= FPGA_URAM_ARB_RUN;
`endif
                end
                FPGA_URAM_ARB_RUN: begin
                    if (accept) begin
                        MemAddr        <= selAddr;
                        MemDataIn      <= selWdata;
                        MemWriteEnable <= selWrite;
                        s1Valid        <= 1'b1;
                        s1Id           <= grantId;
                    end
                end
                default: state <= FPGA_URAM_ARB_RUN;
            endcase
        end
    end

    // S2 lines up with the RAM's registered read data.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s2Valid <= 1'b0;
            s2Id    <= '0;
        end else begin
            s2Valid <= s1Valid;
            s2Id    <= s1Id;
        end
    end

    // A requester cannot be accepted while busy, so set and clear never coincide.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy0 <= 1'b0;
            busy1 <= 1'b0;
        end else begin
            if (Req0Ready) begin
                busy0 <= 1'b1;
            end else if (rsp0Done) begin
                busy0 <= 1'b0;
            end
            if (Req1Ready) begin
                busy1 <= 1'b1;
            end else if (rsp1Done) begin
                busy1 <= 1'b0;
            end
        end
    end

    // Busy keeps the slot empty until its response is consumed, so a load never overwrites.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Rsp0Valid <= 1'b0;
            Rsp0Rdata <= '0;
            Rsp1Valid <= 1'b0;
            Rsp1Rdata <= '0;
        end else begin
            if (s2Valid && (s2Id == 1'b0)) begin
                Rsp0Valid <= 1'b1;
                Rsp0Rdata <= MemDataOut;
            end else if (rsp0Done) begin
                Rsp0Valid <= 1'b0;
            end
            if (s2Valid && (s2Id == 1'b1)) begin
                Rsp1Valid <= 1'b1;
                Rsp1Rdata <= MemDataOut;
            end else if (rsp1Done) begin
                Rsp1Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpga_uram_arb.sv
// Directed bench for fpga_uram_arb with a write-first, 1-cycle-latency RAM model on port A.
// Builds with or without FPGA_URAM_ARB_CLR_EN.
module tb_fpga_uram_arb;
    import fpga_uram_arb_pkg::*;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

`ifdef FPGA_URAM_ARB_CLR_EN
    localparam logic      InitExp  = 1'b0;
    localparam arbState_e StateExp = FPGA_URAM_ARB_CLEAR;
`else
    localparam logic      InitExp  = 1'b1;
    localparam arbState_e StateExp = FPGA_URAM_ARB_RUN;
`endif

    typedef logic [DW-1:0] mem_t [DEPTH];

    function automatic mem_t initImage();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        return m;
    endfunction

    // clock / reset
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic          Req0Valid = 0, Req0Write = 0, Req1Valid = 0, Req1Write = 0;
    logic [AW-1:0] Req0Addr = '0, Req1Addr = '0;
    logic [DW-1:0] Req0Wdata = '0, Req1Wdata = '0;
    logic          Rsp0Ready = 0, Rsp1Ready = 0;
    logic          Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid;
    logic [DW-1:0] Rsp0Rdata, Rsp1Rdata;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemDataIn;
    logic          MemWriteEnable;
    logic [DW-1:0] MemDataOut;
    logic          InitDone;
    arbState_e     DbgState;

    fpga_uram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .MEMDEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Write(Req0Write),
        .Req0Addr(Req0Addr), .Req0Wdata(Req0Wdata),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Write(Req1Write),
        .Req1Addr(Req1Addr), .Req1Wdata(Req1Wdata),
        .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Rdata(Rsp0Rdata),
        .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Rdata(Rsp1Rdata),
        .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemWriteEnable(MemWriteEnable),
        .MemDataOut(MemDataOut), .InitDone(InitDone), .DbgState(DbgState)
    );

    // RAM model: write-first, registered output
    mem_t ram = initImage();
    always @(posedge Clk) begin
        if (MemWriteEnable) begin
            ram[MemAddr] <= MemDataIn;
            MemDataOut   <= MemDataIn;
        end else begin
            MemDataOut <= ram[MemAddr];
        end
    end

    // scoreboard state
    int            passCount  = 0;
    int            checkCount = 0;
    mem_t          shadow = initImage();
    logic [DW-1:0] expQ0[$];
    logic [DW-1:0] expQ1[$];
    int            grantLog[$];
    logic          acc0, acc1;
    logic [DW-1:0] lastRsp0, lastRsp1;

    // driver tasks
    task automatic drive0(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        Req0Valid = v; Req0Write = w; Req0Addr = a; Req0Wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        Req1Valid = v; Req1Write = w; Req1Addr = a; Req1Wdata = d;
    endtask

    // One clock: sample handshakes, score responses, record accepts; returns at next negedge.
    task automatic step();
        logic [DW-1:0] e;
        #1;
        acc0 = Req0Valid && Req0Ready;
        acc1 = Req1Valid && Req1Ready;
        if (Rsp0Valid && Rsp0Ready) begin
            checkCount++;
            if (expQ0.size() == 0) begin
                $display("FAIL rsp0_unexpected: got %h, required no response", Rsp0Rdata);
            end else begin
                e = expQ0.pop_front();
                lastRsp0 = Rsp0Rdata;
                if (Rsp0Rdata !== e) $display("FAIL rsp0_data: got %h, required %h", Rsp0Rdata, e);
                else passCount++;
            end
        end
        if (Rsp1Valid && Rsp1Ready) begin
            checkCount++;
            if (expQ1.size() == 0) begin
                $display("FAIL rsp1_unexpected: got %h, required no response", Rsp1Rdata);
            end else begin
                e = expQ1.pop_front();
                lastRsp1 = Rsp1Rdata;
                if (Rsp1Rdata !== e) $display("FAIL rsp1_data: got %h, required %h", Rsp1Rdata, e);
                else passCount++;
            end
        end
        checkCount++;
        if (acc0 && acc1) $display("FAIL single_grant: got both readies, required at most one");
        else passCount++;
        if (acc0) begin
            grantLog.push_back(0);
            expQ0.push_back(Req0Write ? Req0Wdata : shadow[Req0Addr]);
            if (Req0Write) shadow[Req0Addr] = Req0Wdata;
        end
        if (acc1) begin
            grantLog.push_back(1);
            expQ1.push_back(Req1Write ? Req1Wdata : shadow[Req1Addr]);
            if (Req1Write) shadow[Req1Addr] = Req1Wdata;
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (n < 60 && (Req0Valid || Req1Valid || expQ0.size() != 0 || expQ1.size() != 0)) begin
            step();
            if (acc0) Req0Valid = 1'b0;
            if (acc1) Req1Valid = 1'b0;
            n++;
        end
        checkCount++;
        if (n >= 60) $display("FAIL %s_drain: got %0d cycles without completion, required < 60", name, n);
        else passCount++;
    endtask

`ifdef FPGA_URAM_ARB_CLR_EN
    // Called right after Rst is released; ends on the negedge after InitDone rises.
    task automatic check_clear_seq();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge Clk);
            checkCount++;
            if ({MemWriteEnable, MemAddr, MemDataIn, InitDone, Req0Ready} !== {1'b1, AW'(i), {DW{1'b0}}, 1'b0, 1'b0})
                $display("FAIL clear_word%0d: got we=%b addr=%h din=%h init=%b rdy=%b, required 1 %h 0 0 0",
                         i, MemWriteEnable, MemAddr, MemDataIn, InitDone, Req0Ready, AW'(i));
            else passCount++;
        end
        @(negedge Clk);
        checkCount++;
        if ({InitDone, MemWriteEnable, DbgState} !== {1'b1, 1'b0, FPGA_URAM_ARB_RUN})
            $display("FAIL clear_done: got init=%b we=%b state=%b, required 1 0 1", InitDone, MemWriteEnable, DbgState);
        else passCount++;
        for (int k = 0; k < DEPTH; k++) shadow[k] = '0;
    endtask
`endif

    task automatic do_reset();
        drive0(0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        Rst = 1'b1;
        expQ0.delete(); expQ1.delete(); grantLog.delete();
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
`ifdef FPGA_URAM_ARB_CLR_EN
        check_clear_seq();
`else
        @(negedge Clk);
`endif
    endtask

    task automatic test_reset();
        drive0(0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        checkCount++;
        if ({Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, MemWriteEnable} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, required 00000", {Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, MemWriteEnable});
        else passCount++;
        checkCount++;
        if ({Rsp0Rdata, Rsp1Rdata, MemAddr, MemDataIn} !== '0)
            $display("FAIL reset_data: got %h %h %h %h, required all 0", Rsp0Rdata, Rsp1Rdata, MemAddr, MemDataIn);
        else passCount++;
        checkCount++;
        if (InitDone !== InitExp) $display("FAIL reset_initdone: got %b, required %b", InitDone, InitExp);
        else passCount++;
        checkCount++;
        if (DbgState !== StateExp) $display("FAIL reset_state: got %b, required %b", DbgState, StateExp);
        else passCount++;
        @(negedge Clk);
`ifdef FPGA_URAM_ARB_CLR_EN
        // a read held pending during the clear must be served only afterwards, from zeroed RAM
        Rsp0Ready = 1'b1;
        drive0(1, 0, AW'(5), '0);
        Rst = 1'b0;
        check_clear_seq();
        drain("clear_read");
        checkCount++;
        if (lastRsp0 !== 64'h0) $display("FAIL clear_read5: got %h, required 0", lastRsp0);
        else passCount++;
`else
        Rst = 1'b0;
        @(negedge Clk);
        checkCount++;
        if ({InitDone, DbgState} !== {1'b1, FPGA_URAM_ARB_RUN})
            $display("FAIL run_after_reset: got init=%b state=%b, required 1 1", InitDone, DbgState);
        else passCount++;
`endif
    endtask

    task automatic test_single_wr_rd();
        Rsp0Ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            drive0(1, (t == 0), AW'(3), (t == 0) ? 64'hA5A5 : 64'h0);
            step();
            checkCount++;
            if (!acc0) $display("FAIL single_accept%0d: got no accept, required accept", t);
            else passCount++;
            drive0(0, 0, '0, '0);
            checkCount++;
            if ({MemWriteEnable, MemAddr} !== {(t == 0), AW'(3)} || (t == 0 && MemDataIn !== 64'hA5A5))
                $display("FAIL single_memport%0d: got we=%b addr=%h din=%h", t, MemWriteEnable, MemAddr, MemDataIn);
            else passCount++;
            @(negedge Clk);
            checkCount++;
            if (Rsp0Valid !== 1'b0) $display("FAIL single_early%0d: got rsp0valid=%b, required 0", t, Rsp0Valid);
            else passCount++;
            @(negedge Clk);
            checkCount++;
            if ({Rsp0Valid, Rsp0Rdata} !== {1'b1, 64'hA5A5})
                $display("FAIL single_rsp%0d: got valid=%b data=%h, required 1 a5a5", t, Rsp0Valid, Rsp0Rdata);
            else passCount++;
            if (expQ0.size() != 0) void'(expQ0.pop_front());
            @(negedge Clk);
            checkCount++;
            if (Rsp0Valid !== 1'b0) $display("FAIL single_consumed%0d: got rsp0valid=%b, required 0", t, Rsp0Valid);
            else passCount++;
        end
    endtask

    task automatic test_contention();
        int idx0 = 0;
        int idx1 = 0;
        int n = 0;
        do_reset();
        Rsp0Ready = 1'b1;
        Rsp1Ready = 1'b1;
        while (n < 200 && (idx0 < 8 || idx1 < 8 || expQ0.size() != 0 || expQ1.size() != 0)) begin
            drive0(idx0 < 8, 1, AW'(idx0), 64'hA000 + 64'(idx0));
            drive1(idx1 < 8, 1, AW'(8 + idx1), 64'hB000 + 64'(idx1));
            step();
            if (acc0) idx0++;
            if (acc1) idx1++;
            n++;
        end
        drive0(0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        checkCount++;
        if (n >= 200) $display("FAIL contention_timeout: got idx0=%0d idx1=%0d, required 8 8", idx0, idx1);
        else passCount++;
        checkCount++;
        if (grantLog.size() != 16) $display("FAIL contention_count: got %0d grants, required 16", grantLog.size());
        else passCount++;
        for (int k = 0; k < grantLog.size(); k++) begin
            checkCount++;
            if (grantLog[k] != (k % 2)) $display("FAIL contention_order%0d: got %0d, required %0d", k, grantLog[k], k % 2);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int req0Acc = 0;
        Rsp0Ready = 1'b1;
        Rsp1Ready = 1'b0;
        drive1(1, 0, AW'(8), '0);
        step();
        checkCount++;
        if (!acc1) $display("FAIL bp_accept: got no accept, required accept");
        else passCount++;
        drive1(1, 0, AW'(9), '0);
        while (n < 5 && !Rsp1Valid) begin
            step();
            n++;
        end
        checkCount++;
        if (!Rsp1Valid) $display("FAIL bp_rsp_timeout: got rsp1valid=0, required 1");
        else passCount++;
        drive0(1, 0, AW'(0), '0);
        for (int c = 0; c < 10; c++) begin
            step();
            checkCount++;
            if ({Rsp1Valid, Rsp1Rdata, Req1Ready} !== {1'b1, 64'hB000, 1'b0})
                $display("FAIL bp_hold%0d: got valid=%b data=%h ready=%b, required 1 b000 0", c, Rsp1Valid, Rsp1Rdata, Req1Ready);
            else passCount++;
            if (acc0) begin
                req0Acc++;
                drive0(1, 0, AW'(req0Acc % 8), '0);
            end
        end
        checkCount++;
        if (req0Acc != 3) $display("FAIL bp_req0_served: got %0d accepts, required 3", req0Acc);
        else passCount++;
        drive0(0, 0, '0, '0);
        Rsp1Ready = 1'b1;
        drain("bp");
        checkCount++;
        if (lastRsp1 !== 64'hB001) $display("FAIL bp_next_req1: got %h, required b001", lastRsp1);
        else passCount++;
    endtask

    task automatic test_cross_raw();
        Rsp0Ready = 1'b1;
        Rsp1Ready = 1'b1;
        drive1(1, 1, AW'(7), 64'h1234);
        step();
        checkCount++;
        if (!acc1) $display("FAIL raw_wr_accept: got no accept, required accept");
        else passCount++;
        drive1(0, 0, '0, '0);
        drive0(1, 0, AW'(7), '0);
        step();
        checkCount++;
        if (!acc0) $display("FAIL raw_rd_accept: got no accept, required accept next cycle");
        else passCount++;
        drive0(0, 0, '0, '0);
        drain("raw");
        checkCount++;
        if (lastRsp0 !== 64'h1234) $display("FAIL raw_data: got %h, required 1234", lastRsp0);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] keep;
        logic [DW-1:0] want;
        Rsp0Ready = 1'b1;
        keep = shadow[2];
        drive0(1, 1, AW'(2), 64'h55);
        step();
        checkCount++;
        if (MemWriteEnable !== 1'b1) $display("FAIL mid_inflight: got we=%b, required 1", MemWriteEnable);
        else passCount++;
        Rst = 1'b1;
        drive0(0, 0, '0, '0);
        #1;
        checkCount++;
        if ({Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, MemWriteEnable, MemAddr, MemDataIn, Rsp0Rdata, Rsp1Rdata} !== '0)
            $display("FAIL mid_outputs: got we=%b addr=%h din=%h rv=%b%b, required all 0",
                     MemWriteEnable, MemAddr, MemDataIn, Rsp0Valid, Rsp1Valid);
        else passCount++;
        checkCount++;
        if (InitDone !== InitExp) $display("FAIL mid_initdone: got %b, required %b", InitDone, InitExp);
        else passCount++;
        shadow[2] = keep;
        expQ0.delete(); expQ1.delete();
        @(negedge Clk);
        Rst = 1'b0;
`ifdef FPGA_URAM_ARB_CLR_EN
        check_clear_seq();
        want = 64'h0;
`else
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            checkCount++;
            if (Rsp0Valid !== 1'b0) $display("FAIL mid_dropped%0d: got rsp0valid=%b, required 0", c, Rsp0Valid);
            else passCount++;
        end
        want = 64'hA003;
`endif
        drive0(1, 0, AW'(3), '0);
        drain("mid");
        checkCount++;
        if (lastRsp0 !== want) $display("FAIL mid_next_read: got %h, required %h", lastRsp0, want);
        else passCount++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_wr_rd();
        test_contention();
        test_backpressure();
        test_cross_raw();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
